// File: rtl/bids22_cmd_sequencer.sv
// bids22_cmd_sequencer: buffers host commands and issues them to the
// bids22 master one at a time, returning one response per command.
module bids22_cmd_sequencer #(
    parameter int DATAWIDTH    = 32,
    parameter int FIFODEPTH    = 4,
    parameter int ROUNDTIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_op,
    input  logic [DATAWIDTH-1:0] cmd_data,
    output logic [3:0]           C_op,
    output logic [DATAWIDTH-1:0] C_data,
    output logic                 C_start,
    input  logic                 ready,
    input  logic [2:0]           err,
    input  logic                 roundOver,
    input  logic [DATAWIDTH-1:0] maxBid,
    output logic                 rsp_valid,
    output logic [2:0]           rsp_err,
    output logic [DATAWIDTH-1:0] rsp_maxbid,
    output logic                 busy
);
    localparam int AW = $clog2(FIFODEPTH);
    localparam int TW = $clog2(ROUNDTIMEOUT + 1);
    localparam logic [3:0] OP_STARTROUND = 4'd15;
    localparam logic [2:0] ERR_TIMEOUT = 3'd7;
    localparam logic [TW-1:0] TIMER_LAST = TW'(ROUNDTIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE, CAPTURE, START, WAITROUND, RESPOND
    } state_t;

    state_t state, state_d;

    logic [3:0]           fifo_op   [FIFODEPTH];
    logic [DATAWIDTH-1:0] fifo_data [FIFODEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 full, empty, push, pop;
    logic [3:0]           head_op;
    logic [3:0]           cur_op;
    logic [DATAWIDTH-1:0] cur_data;
    logic [TW-1:0]        timer;
    logic                 timer_clr;
    logic [2:0]           rsp_err_d;
    logic [DATAWIDTH-1:0] rsp_maxbid_d;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign cmd_ready = reset_n && !full;
    assign push      = cmd_valid && cmd_ready;
    assign head_op   = fifo_op[rd_ptr[AW-1:0]];
    assign busy      = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr[AW-1:0]]   <= cmd_op;
            fifo_data[wr_ptr[AW-1:0]] <= cmd_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cur_op   <= '0;
            cur_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                cur_op   <= head_op;
                cur_data <= fifo_data[rd_ptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            rsp_err    <= '0;
            rsp_maxbid <= '0;
        end else begin
            state      <= state_d;
            rsp_err    <= rsp_err_d;
            rsp_maxbid <= rsp_maxbid_d;
            if (timer_clr) begin
                timer <= '0;
            end else if (state == WAITROUND) begin
                timer <= timer + 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state;
        pop          = 1'b0;
        timer_clr    = 1'b0;
        rsp_err_d    = rsp_err;
        rsp_maxbid_d = rsp_maxbid;
        C_op         = '0;
        C_data       = '0;
        C_start      = 1'b0;
        rsp_valid    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && ready) begin
                    pop     = 1'b1;
                    state_d = (head_op == OP_STARTROUND) ? START : ISSUE;
                end
            end
            ISSUE: begin
                C_op    = cur_op;
                C_data  = cur_data;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rsp_err_d    = err;
                rsp_maxbid_d = '0;
                state_d      = RESPOND;
            end
            START: begin
                C_start   = 1'b1;
                timer_clr = 1'b1;
                state_d   = WAITROUND;
            end
            WAITROUND: begin
                C_start = 1'b1;
                // A round ending on the timeout cycle still counts.
                if (roundOver) begin
                    rsp_err_d    = err;
                    rsp_maxbid_d = maxBid;
                    state_d      = RESPOND;
                end else if (timer == TIMER_LAST) begin
                    rsp_err_d    = ERR_TIMEOUT;
                    rsp_maxbid_d = '0;
                    state_d      = RESPOND;
                end
            end
            RESPOND: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/bids22_cmd_sequencer.md
Name: bids22_cmd_sequencer

Overview:
- Upstream control stage for the bids22 bid master. It buffers host commands in a small FIFO and issues them one at a time onto the master's C_op/C_data/C_start inputs.
- Each command waits for the master's ready; the master's err/roundOver/maxBid are returned to the host as one response per command.
- It is the only driver of the master's cin bundle.

Parameters:
- DATAWIDTH, 32, width of C_data, cmd_data, maxBid.
- FIFODEPTH, 4, command FIFO entries; power of two, >=2.
- ROUNDTIMEOUT, 1024, cycles to wait for roundOver before aborting a round.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO not full; transfer when cmd_valid & cmd_ready.
- cmd_op  in  4  opcode, bids22defs opcodes_t encoding: NO_OP=0 … SETBIDCHARGE=8. Value 15 = STARTROUND pseudo-op.
- cmd_data  in  DATAWIDTH  operand.
- C_op  out  4  to master.
- C_data  out  DATAWIDTH  to master.
- C_start  out  1  to master.
- ready  in  1  from master.
- err  in  3  from master, outerrors_t.
- roundOver  in  1  from master.
- maxBid  in  DATAWIDTH  from master.
- rsp_valid  out  1  one-cycle pulse per completed command.
- rsp_err  out  3  captured err; 3'd7 = sequencer timeout.
- rsp_maxbid  out  DATAWIDTH  maxBid at round end, else 0.
- busy  out  1  FSM not IDLE or FIFO non-empty.

Behaviour:
- Reset (async, reset_n low): FIFO empty, FSM IDLE, timer 0. All outputs 0, except cmd_ready=1 once reset_n is high.
- FIFO:
  - Write on cmd_valid & cmd_ready. cmd_ready = !full.
  - Simultaneous push and pop when full is not possible, because cmd_ready is low. When empty, push then pop takes effect the next cycle; there is no fall-through.
  - Pointers wrap modulo FIFODEPTH with an extra wrap bit for the full/empty distinction.
- FSM states: IDLE, ISSUE, CAPTURE, START, WAITROUND, RESPOND.
- IDLE:
  - FIFO non-empty and ready=1: pop the head.
  - cmd_op=15 goes to START. Any other op goes to ISSUE.
  - FIFO non-empty and ready=0: stay in IDLE. C_op=0.
- ISSUE: drive C_op/C_data from the popped entry for exactly one cycle, then go to CAPTURE. NO_OP is still issued and still produces a response.
- CAPTURE: the master presents err for the op issued in the previous cycle. Latch rsp_err=err, rsp_maxbid=0. Go to RESPOND. C_op returns to 0.
- START: assert C_start=1, C_op=0, clear the timer, go to WAITROUND.
- WAITROUND:
  - C_start stays at 1. The timer increments every cycle.
  - If roundOver=1: latch rsp_maxbid=maxBid and rsp_err=err, drop C_start, go to RESPOND.
  - If the timer reaches ROUNDTIMEOUT-1 with no roundOver: rsp_err=7, rsp_maxbid=0, drop C_start, go to RESPOND.
  - roundOver is checked before the timeout, so roundOver arriving on the timeout cycle counts as success.
- RESPOND: rsp_valid=1 for one cycle, then go to IDLE. rsp_err/rsp_maxbid hold until the next response.
- Latency:
  - Plain op: pop cycle to rsp_valid = 3 cycles (IDLE, ISSUE, CAPTURE, then RESPOND).
  - STARTROUND: rsp_valid one cycle after roundOver is seen.
- Strict in-order: one command outstanding at a time. Only the head is ever popped.
- Commands keep being accepted into the FIFO while the FSM is busy.
- Reset mid-round: C_start drops immediately (async). All queued commands are discarded and no response is emitted.
- Unknown opcodes 9..14 are forwarded unchanged; the master reports INVALID_OP, which comes back in rsp_err.

Test Plan:
1. Reset, then push UNLOCK (op 1, data 0xCAFE) with ready=1; master returns err=0 → C_op=1, C_data=0xCAFE for exactly 1 cycle; rsp_valid 3 cycles after the pop; rsp_err=0.
2. Push 5 commands back-to-back with ready=0 → cmd_ready drops after the 4th; 5th held. Raise ready → 4 responses in order; 5th is accepted once the first pop frees an entry.
3. Push STARTROUND; master raises roundOver after 20 cycles with maxBid=0x64 → C_start high for the whole 20 cycles; rsp_maxbid=0x64, rsp_err=0.
4. STARTROUND with ROUNDTIMEOUT=16 and no roundOver → C_start drops after 16 cycles; rsp_err=7.
5. Push op 12 and have the master return err=4 → rsp_err=4. Follow with LOADX (3, 0x10) → issued normally.
6. Assert reset_n low during WAITROUND with 2 commands queued → C_start=0 the same cycle; after release busy=0, no rsp_valid, FIFO empty.
